// File: rtl/fpga_cfg_master.sv
// FPGA-side configuration master: holds the backend in reset, shifts a multi-word frame
// MSB-first over sclk/sdout, then waits for ready with a timeout. Optional parity: CFG_PARITY_EN.
module fpga_cfg_master #(
    parameter  int unsigned WORD_W        = 8,
    parameter  int unsigned NUM_WORDS     = 4,
    parameter  int unsigned SCLK_DIV      = 2,
    parameter  int unsigned RESET_HOLD    = 16,
    parameter  int unsigned READY_TIMEOUT = 1024,
    localparam int unsigned IDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [NUM_WORDS*WORD_W-1:0] i_cfg_data,
    input  logic                        i_ready,
    output logic                        o_resetbAll,
    output logic                        o_sclk,
    output logic                        o_sdout,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_timeout,
    output logic [IDX_W-1:0]            o_word_idx
);

`ifdef CFG_PARITY_EN
    localparam int unsigned FRAME = WORD_W + 1;
`else
    localparam int unsigned FRAME = WORD_W;
`endif
    localparam int unsigned DATA_W  = NUM_WORDS * WORD_W;
    localparam int unsigned BIT_W   = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int unsigned PH_W    = $clog2(2 * SCLK_DIV);
    localparam int unsigned CNT_MAX = (RESET_HOLD > READY_TIMEOUT) ? RESET_HOLD : READY_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_HOLD = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_WAIT_RDY = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [IDX_W-1:0]  word_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              resetb_d, sclk_d, sdout_d, busy_d, done_d, tmo_d;

    // Serial value of bit b of word w; positions past the word LSB carry its odd parity.
    function automatic logic word_bit(input logic [DATA_W-1:0] d,
                                      input logic [IDX_W-1:0]  w,
                                      input logic [BIT_W-1:0]  b);
        logic [WORD_W-1:0] word;
        logic [WORD_W-1:0] sh;
        word = WORD_W'(d >> (int'(w) * WORD_W));
`ifdef CFG_PARITY_EN
        if (int'(b) >= WORD_W) begin
            return ~(^word);
        end
`endif
        sh = word >> (WORD_W - 1 - int'(b));
        return sh[0];
    endfunction

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ph_q        <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            o_word_idx  <= '0;
            o_resetbAll <= 1'b0;
            o_sclk      <= 1'b0;
            o_sdout     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            o_word_idx  <= word_d;
            o_resetbAll <= resetb_d;
            o_sclk      <= sclk_d;
            o_sdout     <= sdout_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_timeout   <= tmo_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        bit_d    = bit_q;
        word_d   = o_word_idx;
        data_d   = data_q;
        resetb_d = o_resetbAll;
        sclk_d   = o_sclk;
        sdout_d  = o_sdout;
        busy_d   = o_busy;
        done_d   = o_done;
        tmo_d    = o_timeout;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_d  = ST_RST_HOLD;
                    data_d   = i_cfg_data;
                    cnt_d    = CNT_W'(RESET_HOLD - 1);
                    resetb_d = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    tmo_d    = 1'b0;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d  = ST_SHIFT;
                    resetb_d = 1'b1;
                    ph_d     = '0;
                    bit_d    = '0;
                    word_d   = '0;
                    sclk_d   = 1'b0;
                    sdout_d  = word_bit(data_q, '0, '0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ph_q == PH_W'(SCLK_DIV - 1)) begin
                    sclk_d = 1'b1;
                    ph_d   = ph_q + 1'b1;
                end else if (ph_q == PH_W'(2 * SCLK_DIV - 1)) begin
                    // Falling edge closes the bit period; the next bit goes out with it
                    sclk_d = 1'b0;
                    ph_d   = '0;
                    if (bit_q == BIT_W'(FRAME - 1)) begin
                        bit_d = '0;
                        if (o_word_idx == IDX_W'(NUM_WORDS - 1)) begin
                            state_d = ST_WAIT_RDY;
                            word_d  = '0;
                            sdout_d = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            word_d  = o_word_idx + 1'b1;
                            sdout_d = word_bit(data_q, o_word_idx + 1'b1, '0);
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sdout_d = word_bit(data_q, o_word_idx, bit_q + 1'b1);
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                // Ready is checked before expiry so a last-cycle ready still succeeds
                if (i_ready) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_W'(READY_TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpga_cfg_master.sv
// Table-driven bench for fpga_cfg_master (2 words x 8 bits, SCLK_DIV=2), plus reset-mid-shift sequence.
module tb_fpga_cfg_master;

    localparam int WORD_W    = 8;
    localparam int NUM_WORDS = 2;
    localparam int SCLK_DIV  = 2;
    localparam int HOLD      = 16;
    localparam int TMO       = 1024;
`ifdef CFG_PARITY_EN
    localparam int FRAME = WORD_W + 1;
`else
    localparam int FRAME = WORD_W;
`endif
    localparam int NB = NUM_WORDS * FRAME;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_ready;
    logic [15:0] i_cfg_data;
    logic        o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout;
    logic [0:0]  o_word_idx;

    int tests  = 0;
    int failed = 0;

    fpga_cfg_master #(
        .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .SCLK_DIV(SCLK_DIV),
        .RESET_HOLD(HOLD), .READY_TIMEOUT(TMO)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_cfg_data(i_cfg_data),
        .i_ready(i_ready), .o_resetbAll(o_resetbAll), .o_sclk(o_sclk), .o_sdout(o_sdout),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_word_idx(o_word_idx)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] data;       // {word1, word0}
        logic [15:0] bits;       // expected stream, first bit at MSB (no parity)
        logic [1:0]  par;        // par[k] = odd parity bit of word k
        bit          ready_early;// i_ready high for the whole frame
        int          ready_delay;// cycles after WAIT_RDY entry; -1 = never
        int          inject;     // sclk rise after which a start with other data is pulsed; -1 = none
        bit          exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int          cyc;
        int          rises;
        int          k;
        int          d;
        logic        prev;
        logic        idx_ok;
        bit          injected;
        logic [NB-1:0] got;
        logic [NB-1:0] exp_bits;
`ifdef CFG_PARITY_EN
        exp_bits = {v.bits[15:8], v.par[0], v.bits[7:0], v.par[1]};
`else
        exp_bits = v.bits;
`endif
        i_cfg_data = v.data;
        i_ready    = v.ready_early;
        i_start    = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("start_flags", 32'({o_busy, o_resetbAll, o_done, o_timeout}), 32'b1000);

        cyc = 0;
        while (!o_resetbAll && cyc < 100) begin
            cyc++;
            @(negedge i_clk);
        end
        check("reset_hold_len", 32'(cyc), 32'(HOLD));

        // Collect the bit on every sclk rise until the final fall
        cyc = 0; rises = 0; prev = o_sclk; idx_ok = 1'b1; injected = 0; got = '0;
        while (!(rises == NB && !o_sclk) && cyc < 500) begin
            @(negedge i_clk);
            cyc++;
            i_start = 1'b0;
            if (!prev && o_sclk) begin
                got = {got[NB-2:0], o_sdout};
                if (32'(o_word_idx) != 32'(rises / FRAME)) idx_ok = 1'b0;
                rises++;
                if (rises == v.inject && !injected) begin
                    injected   = 1;
                    i_start    = 1'b1;
                    i_cfg_data = ~v.data;
                end
            end
            prev = o_sclk;
        end
        i_start = 1'b0;
        check("shift_len", 32'(cyc), 32'(NB * 2 * SCLK_DIV));
        check("bit_stream", 32'(got), 32'(exp_bits));
        check("word_idx", 32'(idx_ok), 32'd1);
        check("wait_entry", 32'({o_sclk, o_sdout, o_word_idx, o_busy, o_resetbAll}), 32'b00011);

        d = v.ready_early ? 0 : v.ready_delay;
        if (d == 0) i_ready = 1'b1;
        k = 0;
        while (o_busy && k < 1100) begin
            @(negedge i_clk);
            k++;
            if (d > 0 && k == d) i_ready = 1'b1;
        end
        check("wait_len", 32'(k), v.exp_done ? 32'(d + 1) : 32'(TMO));
        i_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        check("final_flags", 32'({o_busy, o_done, o_timeout, o_resetbAll, o_sclk}),
              v.exp_done ? 32'b01010 : 32'b00110);
    endtask

    initial begin
        vecs[0] = '{16'h3CA5, 16'hA53C, 2'b11, 1'b0,    5, -1, 1'b1};
        vecs[1] = '{16'h00FF, 16'hFF00, 2'b11, 1'b1,    0, -1, 1'b1};
        vecs[2] = '{16'h8001, 16'h0180, 2'b00, 1'b0, 1023, -1, 1'b1};
        vecs[3] = '{16'h5A7E, 16'h7E5A, 2'b11, 1'b0,   -1, -1, 1'b0};
        vecs[4] = '{16'h3CA5, 16'hA53C, 2'b11, 1'b0,    2,  3, 1'b1};

        i_reset = 1'b1; i_start = 1'b1; i_ready = 1'b1; i_cfg_data = 16'hFFFF;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", 32'({o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout, o_word_idx}), 32'd0);
        i_start = 1'b0; i_ready = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        check("idle_after_reset", 32'({o_resetbAll, o_busy, o_done, o_timeout}), 32'd0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Reset after 5 bits abandons the frame; the next start resends from bit 0
        begin
            int   rises;
            int   cyc;
            logic prev;
            i_cfg_data = 16'h1234;
            i_start    = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
            rises = 0; cyc = 0; prev = o_sclk;
            while (rises < 5 && cyc < 200) begin
                @(negedge i_clk);
                cyc++;
                if (!prev && o_sclk) rises++;
                prev = o_sclk;
            end
            check("mid_shift_reached", 32'(rises), 32'd5);
            i_reset = 1'b1;
            @(negedge i_clk);
            i_reset = 1'b0;
            check("mid_reset_outputs",
                  32'({o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout, o_word_idx}), 32'd0);
            @(negedge i_clk);
            check("mid_reset_idle", 32'({o_busy, o_resetbAll}), 32'd0);
        end
        run_frame(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpga_cfg_master.md
# fpga_cfg_master

Parametrised FPGA-side configuration master that drives the chip backend's reset and serial configuration port. On a start request it holds the backend in reset, shifts `NUM_WORDS` configuration words of `WORD_W` bits MSB-first over `o_sclk`/`o_sdout`, then waits for the backend's `i_ready` with a timeout. It replaces the fixed single-frame FPGA model with a configurable word width, word count and serial clock rate, a completion/timeout status and an optional per-word parity bit.

## Interface
- `WORD_W`, 8: bits per configuration word.
- `NUM_WORDS`, 4: words per configuration frame; word 0 is sent first.
- `SCLK_DIV`, 2: `o_sclk` half-period in `i_clk` cycles (≥1).
- `RESET_HOLD`, 16: cycles `o_resetbAll` is held low before shifting (≥1).
- `READY_TIMEOUT`, 1024: maximum cycles to wait for `i_ready` after the last bit.

- `i_clk`, in, 1: single clock, rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_start`, in, 1: start request; one-cycle pulse or level.
- `i_cfg_data`, in, NUM_WORDS*WORD_W: configuration payload; word k is `[k*WORD_W +: WORD_W]`. Latched on start.
- `i_ready`, in, 1: backend ready; sampled synchronously.
- `o_resetbAll`, out, 1: active-low backend reset.
- `o_sclk`, out, 1: serial clock to the backend.
- `o_sdout`, out, 1: serial data to the backend.
- `o_busy`, out, 1: high from the start acceptance edge until DONE or ERROR.
- `o_done`, out, 1: sticky success flag.
- `o_timeout`, out, 1: sticky timeout flag.
- `o_word_idx`, out, clog2(NUM_WORDS) (minimum 1): index of the word being shifted; 0 outside SHIFT.

## Operation
- States: IDLE, RST_HOLD, SHIFT, WAIT_RDY, DONE, ERROR.
- **Reset values:** while `i_reset` is high, all outputs are 0 (`o_resetbAll`=0, so the backend is held in reset) and the state is IDLE.
- **Start acceptance:** `i_start` is accepted only in IDLE, DONE or ERROR.
  - The edge that accepts it latches `i_cfg_data`, clears `o_done`/`o_timeout`, sets `o_busy`=1 and `o_resetbAll`=0, and enters RST_HOLD.
  - `i_start` is ignored in RST_HOLD, SHIFT and WAIT_RDY.
- **RST_HOLD:** lasts exactly RESET_HOLD cycles. On the exit edge `o_resetbAll`=1, the state becomes SHIFT, and the first bit is driven on `o_sdout`.
- **SHIFT:** each bit occupies 2*SCLK_DIV cycles.
  - `o_sdout` changes only while `o_sclk`=0, at the start of the bit period.
  - `o_sclk` rises SCLK_DIV cycles later and falls SCLK_DIV cycles after that.
  - The backend samples on the rising edge.
  - Bit order: word 0 first, MSB first within each word.
  - After the final falling edge, `o_sclk`=0 and `o_sdout`=0, and the state becomes WAIT_RDY.
- **WAIT_RDY:**
  - If `i_ready`=1 is sampled within READY_TIMEOUT cycles (counting from entry, entry cycle included): go to DONE with `o_done`=1 and `o_busy`=0 on the next edge.
  - Otherwise go to ERROR with `o_timeout`=1 and `o_busy`=0.
  - `i_ready` is ignored in every other state.
- **DONE/ERROR:** hold their flags and keep `o_resetbAll`=1 until the next accepted start or reset.

## Timing
- Start edge to `o_resetbAll` rising: RESET_HOLD cycles.
- Shift duration: NUM_WORDS*FRAME*2*SCLK_DIV cycles.
  - FRAME = WORD_W, or WORD_W+1 when `CFG_PARITY_EN` is defined.
- If `i_ready` is already high on WAIT_RDY entry: `o_done` is set on the following edge (1-cycle latency).
- If `i_ready` rises on the edge that would expire the timeout, ready wins.
- **Reset mid-operation:** the next edge restores all reset values. A partial frame is abandoned; there is no resume.
- `i_cfg_data` changes after the start edge have no effect on the frame in flight.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `CFG_PARITY_EN` defined:
  - After the LSB of each word, one extra bit period sends odd parity (the XOR of the word bits, inverted), so each word plus its parity bit has an odd number of ones.
  - `o_word_idx` stays on that word during its parity bit.
- `CFG_PARITY_EN` undefined: frames are exactly WORD_W bits per word and no parity logic exists.

## Test plan
- **Basic frame:** WORD_W=8, NUM_WORDS=2, SCLK_DIV=2, data {word1=0x3C, word0=0xA5}, pulse start.
  - `o_resetbAll` is low for 16 cycles.
  - Bits sampled on the 16 `o_sclk` rises are 1010_0101_0011_1100.
  - The shift takes 64 cycles.
- **Ready handshake:** same frame, `i_ready` raised 5 cycles after WAIT_RDY entry.
  - `o_done`=1 and `o_busy`=0 on the next edge.
  - `o_timeout` stays 0.
- **Timeout:** `i_ready` held 0 → `o_timeout`=1 exactly 1024 cycles after WAIT_RDY entry, and `o_done`=0.
- **Reset mid-shift:** assert `i_reset` for 1 cycle after 5 bits.
  - All outputs read 0 the next cycle.
  - A new start sends the full frame from bit 0.
- **Start while busy:** pulse `i_start` during SHIFT with different data → frame and timing are unchanged; the original data is sent.
- **Parity (`CFG_PARITY_EN`):** word 0x0A5 → bit stream 1010_0101_1. Total shift is 18 bit periods for 2 words.
